// File: rtl/subtrator_serial.sv
// Digit-serial add/subtract unit: DIGIT bits per cycle, LSB digit first, through
// one ripple slice and a registered borrow/carry; result lands after WIDTH/DIGIT edges.
module subtrator_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic             modo,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ocupado,
  output logic             pronto,
  output logic [WIDTH:0]   s,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] OCIOSO = 1'b0;
  localparam logic [0:0] CALC   = 1'b1;

  // Handshake: inicio is taken only while ocupado=0; pronto pulses one cycle
  // when s/zero are updated, and inicio may be reasserted in that same cycle.
  logic [0:0]             state;
  logic [CW-1:0]          cnt;
  logic                   bc;
  logic                   modo_r;
  logic [WIDTH-1:0]       a_sr;
  logic [WIDTH-1:0]       b_sr;
  logic [WIDTH-1:0]       res_sr;
  logic [DIGIT:0]         slice;
  logic [WIDTH+DIGIT-1:0] res_cat;

  // Top bit of the (DIGIT+1)-bit slice is the carry in add mode and the sign
  // of the difference, i.e. the borrow, in subtract mode.
  always_comb begin
    slice = '0;
    if (modo_r)
      slice = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, bc};
    else
      slice = {1'b0, a_sr[DIGIT-1:0]} - {1'b0, b_sr[DIGIT-1:0]} - {{DIGIT{1'b0}}, bc};
    res_cat = {slice[DIGIT-1:0], res_sr};
  end

  assign ocupado = (state == CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OCIOSO;
      cnt    <= '0;
      bc     <= 1'b0;
      modo_r <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      s      <= '0;
      zero   <= 1'b0;
      pronto <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (state == OCIOSO) begin
        if (inicio) begin
          a_sr   <= a;
          b_sr   <= b;
          modo_r <= modo;
          bc     <= 1'b0;
          cnt    <= '0;
          state  <= CALC;
        end
      end else begin
        a_sr   <= a_sr >> DIGIT;
        b_sr   <= b_sr >> DIGIT;
        res_sr <= res_cat[WIDTH+DIGIT-1:DIGIT];
        bc     <= slice[DIGIT];
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(N - 1)) begin
          s      <= {slice[DIGIT], res_cat[WIDTH+DIGIT-1:DIGIT]};
          zero   <= (res_cat[WIDTH+DIGIT-1:DIGIT] == '0);
          pronto <= 1'b1;
          cnt    <= '0;
          state  <= OCIOSO;
        end
      end
    end
  end

endmodule

// File: doc/subtrator_serial.md
Name: subtrator_serial

Overview:
- Multi-cycle, parametrised add/subtract unit for the ULA datapath; successor to the 8-bit ripple subtractor.
- Processes DIGIT bits per clock, LSB digit first, through one DIGIT-bit ripple slice and a registered borrow/carry, trading latency for area.
- Start/done handshake.
- Result format matches the combinational unit: WIDTH result bits plus borrow/carry in the MSB.

Parameters:
- WIDTH, 8, operand width in bits. Must be a multiple of DIGIT.
- DIGIT, 1, bits processed per cycle. Latency N = WIDTH/DIGIT cycles.

Ports:
- clk     input   1          single clock, all state on rising edge
- rst     input   1          synchronous, active-high reset
- inicio  input   1          start request, sampled only when idle
- modo    input   1          0 = a - b, 1 = a + b; latched with operands
- a       input   WIDTH      minuend / addend A
- b       input   WIDTH      subtrahend / addend B
- ocupado output  1          high while an operation is in progress
- pronto  output  1          one-cycle pulse: s/zero just updated
- s       output  WIDTH+1    s[WIDTH-1:0] result; s[WIDTH] = borrow (sub) or carry (add)
- zero    output  1          1 when s[WIDTH-1:0] == 0 for the last result

Behaviour:
- Reset (rst=1 at an edge, overrides everything):
  - State goes to OCIOSO.
  - ocupado=0, pronto=0, s=0, zero=0.
  - Borrow/carry register and digit counter cleared.
  - An operation in progress is aborted and produces no pronto.
- States: OCIOSO and CALC.
- OCIOSO:
  - When inicio=1 at an edge: latch a, b, modo into shift registers.
  - Initialise the borrow/carry register to 0; counter = 0; go to CALC.
  - ocupado=1 from the next cycle.
  - With inicio=0, s/zero hold their values.
- CALC, per edge:
  - Compute the low DIGIT bits of the operand registers with the borrow/carry register:
    - Sub: diff = a - b - borrow; borrow_out = 1 when a < b + borrow_in (unsigned).
    - Add: sum = a + b + carry.
  - Shift the result digit into the result register from the top; shift operands right by DIGIT.
  - Update the borrow/carry register; counter increments.
- On the edge where the counter reaches N-1 (the Nth processing edge):
  - s <= {final borrow/carry, assembled result}; zero updated from the same result.
  - pronto <= 1 for exactly one cycle; ocupado <= 0; state -> OCIOSO.
- Timing: inicio accepted at edge T0 gives pronto high in the cycle after edge T0+N. Total latency is N+1 edges from the start edge to the visible result.
- inicio while ocupado=1 is ignored; no queueing.
- Back-to-back: inicio high in the pronto cycle is accepted. pronto drops next cycle; s holds the previous result until the new one completes.
- Operands/modo may change after acceptance without affecting the operation.
- Arithmetic is unsigned, modulo 2^WIDTH.
  - s[WIDTH] equals the borrow out of the MSB stage in sub mode, and the carry out in add mode.
  - Results are bit-identical to the combinational unit for WIDTH=8, modo=0.
- zero reflects only s[WIDTH-1:0], never the borrow/carry bit.

Test Plan:
- WIDTH=8, DIGIT=1, modo=0, a=8'h05, b=8'h03, pulse inicio -> ocupado high 8 cycles; pronto single pulse 9 edges after start; s=9'h002, zero=0.
- Same config, a=8'h03, b=8'h05 -> s=9'h1FE (borrow=1); a=8'h00, b=8'h00 -> s=9'h000, zero=1.
- modo=1, a=8'hFF, b=8'h01 -> s=9'h100, zero=1. Then a=8'h7F, b=8'h01 -> s=9'h080, zero=0.
- Handshake: inicio held high throughout with changing a/b -> each operation uses operands latched at acceptance, one pronto per operation, back-to-back accept on the pronto cycle, no extra starts while ocupado.
- rst asserted on the 4th CALC cycle -> next cycle ocupado=0, s=0, zero=0, no pronto. A fresh start (a=8'hA0, b=8'h0A) yields 9'h096.
- WIDTH=16, DIGIT=4: a=16'h1234, b=16'h4321 -> pronto 5 edges after start, s=17'h1CF13. Random-vs-model sweep over both modes.
